// File: rtl/divider_8b_by_4b.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient bit per cycle.
// Optional macro DIVIDER_DBZ_FAST_EN short-circuits divide-by-zero through a two-cycle FAST state.
module divider_8b_by_4b #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   x,
    input  logic [N-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   q,
    output logic [N-1:0]     r,
    output logic             dbz
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

`ifdef DIVIDER_DBZ_FAST_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2,
        S_FAST = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
`endif

    state_t          state_r;
    logic [W-1:0]    qsr_r;
    logic [N-1:0]    div_r;
    logic [N:0]      rem_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    q_r;
    logic [N-1:0]    r_r;
    logic            dbz_r;
    logic            out_valid_r;
    logic            in_ready_r;

    logic [N:0]      rem_sh_s;
    logic [N:0]      rem_nx_s;
    logic [W-1:0]    qsr_nx_s;
    logic            bit_s;

    // One restoring step: shift in the next dividend bit, subtract when the divisor fits.
    always_comb begin
        rem_sh_s = {rem_r[N-1:0], qsr_r[W-1]};
        rem_nx_s = rem_sh_s;
        bit_s    = 1'b0;
        if (rem_sh_s >= {1'b0, div_r}) begin
            rem_nx_s = rem_sh_s - {1'b0, div_r};
            bit_s    = 1'b1;
        end else begin
            rem_nx_s = rem_sh_s;
            bit_s    = 1'b0;
        end
        qsr_nx_s = {qsr_r[W-2:0], bit_s};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            qsr_r       <= {W{1'b0}};
            div_r       <= {N{1'b0}};
            rem_r       <= {(N+1){1'b0}};
            cnt_r       <= {CW{1'b0}};
            q_r         <= {W{1'b0}};
            r_r         <= {N{1'b0}};
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready_r) begin
                        qsr_r      <= x;
                        div_r      <= y;
                        rem_r      <= {(N+1){1'b0}};
                        cnt_r      <= {CW{1'b0}};
                        in_ready_r <= 1'b0;
`ifdef DIVIDER_DBZ_FAST_EN
                        if (y == {N{1'b0}}) begin
                            state_r <= S_FAST;
                        end else begin
                            state_r <= S_RUN;
                        end
`else
                        state_r    <= S_RUN;
`endif
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                S_RUN: begin
                    rem_r <= rem_nx_s;
                    qsr_r <= qsr_nx_s;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == CW'(W - 1)) begin
                        q_r         <= qsr_nx_s;
                        r_r         <= rem_nx_s[N-1:0];
                        dbz_r       <= (div_r == {N{1'b0}});
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end
                end
`ifdef DIVIDER_DBZ_FAST_EN
                // Held for two cycles so the fast path reports with latency 2.
                S_FAST: begin
                    if (cnt_r == CW'(1)) begin
                        q_r         <= {W{1'b1}};
                        r_r         <= qsr_r[N-1:0];
                        dbz_r       <= 1'b1;
                        out_valid_r <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign q         = q_r;
    assign r         = r_r;
    assign dbz       = dbz_r;

endmodule

// File: tb/tb_divider_8b_by_4b.sv
// Directed self-checking bench for divider_8b_by_4b (N=4); fast-path latency follows DIVIDER_DBZ_FAST_EN.
module tb_divider_8b_by_4b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] x = 8'd0;
    logic [3:0] y = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] q;
    logic [3:0] r;
    logic       dbz;

    int n_checks = 0;
    int n_fail   = 0;

    divider_8b_by_4b #(.N(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one operation, wait for the result and complete the output handshake.
    task automatic run_op(input logic [7:0] xv, input logic [3:0] yv, output int lat,
                          output logic [7:0] qo, output logic [3:0] ro, output logic dbzo);
        int guard;
        guard = 0;
        while (!in_ready && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1;
        x = xv;
        y = yv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        qo = q;
        ro = r;
        dbzo = dbz;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [7:0] qo;
        logic [3:0] ro;
        logic dbzo;
        int exp_dbz_lat;

`ifdef DIVIDER_DBZ_FAST_EN
        exp_dbz_lat = 2;
`else
        exp_dbz_lat = 8;
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_q", q, 0);
        check_eq("rst_r", r, 0);
        check_eq("rst_dbz", dbz, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_in_ready", in_ready, 1);

        // basic divide with latency and hold after handshake
        run_op(8'd200, 4'd7, lat, qo, ro, dbzo);
        check_eq("basic_q", qo, 28);
        check_eq("basic_r", ro, 4);
        check_eq("basic_dbz", dbzo, 0);
        check_eq("basic_lat", lat, 8);
        check_eq("hold_q", q, 28);
        check_eq("hold_r", r, 4);
        check_eq("hold_out_valid", out_valid, 0);
        check_eq("hold_in_ready", in_ready, 1);

        // edges
        run_op(8'd255, 4'd1, lat, qo, ro, dbzo);
        check_eq("edge255_q", qo, 255);
        check_eq("edge255_r", ro, 0);
        run_op(8'd0, 4'd9, lat, qo, ro, dbzo);
        check_eq("edge0_q", qo, 0);
        check_eq("edge0_r", ro, 0);
        run_op(8'd14, 4'd15, lat, qo, ro, dbzo);
        check_eq("edge14_q", qo, 0);
        check_eq("edge14_r", ro, 14);

        // divide by zero
        run_op(8'hA7, 4'd0, lat, qo, ro, dbzo);
        check_eq("dbz_q", qo, 8'hFF);
        check_eq("dbz_r", ro, 4'h7);
        check_eq("dbz_flag", dbzo, 1);
        check_eq("dbz_lat", lat, exp_dbz_lat);

        // multiplier inverse sweep
        for (int a = 1; a <= 15; a++) begin
            for (int b = 1; b <= 15; b++) begin
                run_op(8'(a * b), 4'(b), lat, qo, ro, dbzo);
                check_eq("inv_q", qo, a);
                check_eq("inv_r", ro, 0);
            end
        end

        // exhaustive identity check
        for (int xv = 0; xv <= 255; xv++) begin
            for (int yv = 1; yv <= 15; yv++) begin
                run_op(8'(xv), 4'(yv), lat, qo, ro, dbzo);
                check_eq("exh_q", qo, xv / yv);
                check_eq("exh_r", ro, xv % yv);
            end
        end

        // backpressure with in_valid held high
        in_valid = 1'b1;
        x = 8'd50;
        y = 4'd6;
        @(posedge clk); #1;
        check_eq("bp_busy", in_ready, 0);
        x = 8'd77;
        y = 4'd5;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_lat1", lat, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_eq("bp_q", q, 8);
            check_eq("bp_r", r, 2);
            check_eq("bp_in_ready", in_ready, 0);
            check_eq("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("bp_rel_out_valid", out_valid, 0);
        check_eq("bp_rel_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("bp_second_accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("bp_lat2", lat, 8);
        check_eq("bp2_q", q, 15);
        check_eq("bp2_r", r, 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset abort mid-run
        in_valid = 1'b1;
        x = 8'd100;
        y = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_q", q, 0);
        check_eq("abort_r", r, 0);
        check_eq("abort_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'd100, 4'd3, lat, qo, ro, dbzo);
        check_eq("after_abort_q", qo, 33);
        check_eq("after_abort_r", ro, 1);
        check_eq("after_abort_lat", lat, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
